subset_sum_job_driver: RTL and testbench
========================================

// Module: subset_sum_job_driver
// PURPOSE
//  Initiator side of the Full_Node_Tree solve interface. Collects N_of_numbers operands serially over a valid/ready stream plus a target.
//  Drives numbers_flat/target/en/start into the tree, waits for done, and returns isTargetMet through a valid/ready result port.
//  Sits between the host-side operand stream and one tree instance; one job in flight at a time.
// PARAMETERS
//  N_of_numbers    3     operand count per job
//  N_of_bits       4     operand width
//  TIMEOUT_CYCLES  1024  watchdog limit in ARM+WAIT (used only with SUBSET_SUM_TIMEOUT_EN)
//  TGT_W (localparam) = $clog2(N_of_numbers*(2**N_of_bits-1))+1
// PORTS
//  clk           in   1                      clock, rising edge
//  rst_n         in   1                      synchronous reset, active-low
//  in_valid      in   1                      operand beat valid
//  in_ready      out  1                      operand beat accepted when valid&ready
//  in_data       in   N_of_bits              operand value
//  in_target     in   TGT_W                  target, sampled with the last operand beat
//  numbers_flat  out  N_of_bits*N_of_numbers operands to tree, beat k -> [k*N_of_bits +: N_of_bits]
//  target        out  TGT_W                  target to tree
//  en            out  1                      tree enable
//  start         out  1                      one-cycle start pulse
//  busy          in   1                      tree busy
//  done          in   1                      tree done (level)
//  isTargetMet   in   1                      tree result, valid while done=1
//  res_valid     out  1                      result available
//  res_ready     in   1                      result consumed when valid&ready
//  res_met       out  1                      captured isTargetMet
//  res_timeout   out  1                      watchdog fired (tied 0 without macro)
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge, any state): state=FILL, beat count=0, numbers_flat=0, target=0, en=0, start=0, in_ready=0 for that cycle, res_valid=0, res_met=0, res_timeout=0.
//  FILL: in_ready=1. Each accepted beat writes slot cnt, cnt++. Beat cnt==N_of_numbers-1 also latches in_target -> target; cnt clears; go START.
//  START: in_ready=0, start=1 for exactly this cycle, en=1; go ARM.
//  ARM: en=1; wait done==0 (tree dropped stale done of previous job); go WAIT. If done already 0, leave ARM next cycle.
//  WAIT: en=1; on first cycle with done==1: res_met<=isTargetMet, res_valid<=1, go RESULT. busy is informational only.
//  RESULT: en=0; hold res_valid/res_met stable until res_ready=1; that cycle res_valid->0, go FILL. No new beats accepted while RESULT.
//  numbers_flat/target stable from START until next FILL beat overwrites them.
//  Latency: last beat accepted at cycle t -> start at t+1 -> earliest res_valid at t+3 (tree done at t+2 with done low in ARM at t+2... i.e. min 1 cycle ARM).
//  in_valid with in_ready=0 is ignored; no beat loss, no double count.
//  Target width TGT_W covers max sum N*(2^B-1); no truncation.
// CONFIGURATION
//  SUBSET_SUM_TIMEOUT_EN defined: cycle counter runs in ARM+WAIT, cleared on entry to START; reaching TIMEOUT_CYCLES -> res_valid=1, res_met=0, res_timeout=1, go RESULT, en=0.
//  Not defined: no counter, ARM/WAIT wait indefinitely, res_timeout constant 0.
// STRUCTURE
//  Package subset_sum_pkg: state enum {FILL,START,ARM,WAIT,RESULT}, tgt_width(N,B) function, default params.
//  Sub-module subset_sum_deser: beat counter + slot writer + target latch (FILL logic); top holds FSM, handshakes, watchdog.
// TESTING
//  N=3,B=4: beats 2,5,9, target 14 -> one start pulse, tree done -> res_valid=1, res_met=1.
//  N=5: beats 4,6,12,14,8, target 22 -> res_met=1; repeat with target 11 -> res_met=0; numbers_flat slot order checked.
//  res_ready held 0 for 10 cycles -> res_valid/res_met stable, in_ready=0, no new start.
//  in_valid toggling every other cycle during FILL -> exactly N beats captured, start once.
//  rst_n low for one cycle while in WAIT -> all outputs at reset values next cycle, FILL with cnt=0.
//  With SUBSET_SUM_TIMEOUT_EN, TIMEOUT_CYCLES=16, done held 0 -> res_valid at 16 cycles after ARM entry, res_timeout=1, res_met=0.

Source files
------------

// File: rtl/subset_sum_pkg.sv
// Shared state encoding, default parameters and target-width helper
// for the subset-sum job driver.
package subset_sum_pkg;

  localparam int DEF_N       = 3;
  localparam int DEF_B       = 4;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [2:0] {
    S_FILL,
    S_START,
    S_ARM,
    S_WAIT,
    S_RESULT
  } state_e;

  // Wide enough to hold the sum of every operand at its maximum value.
  function automatic int tgt_width(input int n, input int b);
    return $clog2(n * ((2 ** b) - 1)) + 1;
  endfunction

endpackage

// File: rtl/subset_sum_deser.sv
// Operand deserializer: beat counter, slot writer and target latch
// used while the job driver is filling a new job.
module subset_sum_deser
  import subset_sum_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int B  = DEF_B,
  parameter int TW = tgt_width(DEF_N, DEF_B)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          take_i,
  input  logic [B-1:0]  data_i,
  input  logic [TW-1:0] target_i,
  output logic          last_o,
  output logic [N*B-1:0] flat_o,
  output logic [TW-1:0] target_o
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [CW-1:0]  cnt_q;
  logic [N*B-1:0] flat_q;
  logic [TW-1:0]  tgt_q;

  assign last_o   = take_i && (cnt_q == LAST);
  assign flat_o   = flat_q;
  assign target_o = tgt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      flat_q <= '0;
      tgt_q  <= '0;
    end else if (take_i) begin
      flat_q[int'(cnt_q) * B +: B] <= data_i;
      if (cnt_q == LAST) begin
        cnt_q <= '0;
        tgt_q <= target_i;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/subset_sum_job_driver.sv
// Job driver for one Full_Node_Tree: fill operands, start, await done.
// Optional watchdog enabled by defining SUBSET_SUM_TIMEOUT_EN.
module subset_sum_job_driver
  import subset_sum_pkg::*;
#(
  parameter int N_of_numbers = DEF_N,
  parameter int N_of_bits    = DEF_B
`ifdef SUBSET_SUM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT
`endif
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [N_of_bits-1:0] in_data,
  input  logic [tgt_width(N_of_numbers, N_of_bits)-1:0] in_target,
  output logic [N_of_bits*N_of_numbers-1:0] numbers_flat,
  output logic [tgt_width(N_of_numbers, N_of_bits)-1:0] target,
  output logic en,
  output logic start,
  input  logic busy,
  input  logic done,
  input  logic isTargetMet,
  output logic res_valid,
  input  logic res_ready,
  output logic res_met,
  output logic res_timeout
);

  localparam int TGT_W = tgt_width(N_of_numbers, N_of_bits);

  state_e state_q;
  logic   in_ready_q;
  logic   start_q;
  logic   en_q;
  logic   res_valid_q;
  logic   res_met_q;
  logic   res_timeout_q;
  logic   take;
  logic   last;
  logic   to_hit;
  logic   unused_busy;

  assign unused_busy = busy;
  assign take        = in_valid && in_ready_q;

  subset_sum_deser #(
    .N  (N_of_numbers),
    .B  (N_of_bits),
    .TW (TGT_W)
  ) u_deser (
    .clk      (clk),
    .rst_n    (rst_n),
    .take_i   (take),
    .data_i   (in_data),
    .target_i (in_target),
    .last_o   (last),
    .flat_o   (numbers_flat),
    .target_o (target)
  );

`ifdef SUBSET_SUM_TIMEOUT_EN
  localparam int TMW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMW-1:0] tmr_q;

  always_ff @(posedge clk) begin
    if (!rst_n || state_q == S_START) begin
      tmr_q <= '0;
    end else if (state_q == S_ARM || state_q == S_WAIT) begin
      tmr_q <= tmr_q + 1'b1;
    end
  end

  assign to_hit = (tmr_q == TMW'(TIMEOUT_CYCLES - 1));
`else
  assign to_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_FILL;
      in_ready_q    <= 1'b0;
      start_q       <= 1'b0;
      en_q          <= 1'b0;
      res_valid_q   <= 1'b0;
      res_met_q     <= 1'b0;
      res_timeout_q <= 1'b0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        S_FILL: begin
          in_ready_q <= 1'b1;
          if (last) begin
            in_ready_q <= 1'b0;
            start_q    <= 1'b1;
            en_q       <= 1'b1;
            state_q    <= S_START;
          end
        end
        S_START: state_q <= S_ARM;
        // A stale done from the previous job must drop before we trust it.
        S_ARM: begin
          if (to_hit) begin
            res_valid_q   <= 1'b1;
            res_met_q     <= 1'b0;
            res_timeout_q <= 1'b1;
            en_q          <= 1'b0;
            state_q       <= S_RESULT;
          end else if (!done) begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (done) begin
            res_valid_q <= 1'b1;
            res_met_q   <= isTargetMet;
            en_q        <= 1'b0;
            state_q     <= S_RESULT;
          end else if (to_hit) begin
            res_valid_q   <= 1'b1;
            res_met_q     <= 1'b0;
            res_timeout_q <= 1'b1;
            en_q          <= 1'b0;
            state_q       <= S_RESULT;
          end
        end
        S_RESULT: begin
          if (res_ready) begin
            res_valid_q   <= 1'b0;
            res_timeout_q <= 1'b0;
            in_ready_q    <= 1'b1;
            state_q       <= S_FILL;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign in_ready    = in_ready_q;
  assign start       = start_q;
  assign en          = en_q;
  assign res_valid   = res_valid_q;
  assign res_met     = res_met_q;
  assign res_timeout = res_timeout_q;

endmodule

// File: tb/tb_subset_sum_job_driver.sv
// Scoreboard bench for subset_sum_job_driver with N=3 and N=5 instances,
// each paired with a behavioural tree that answers a few cycles after start.
module tb_subset_sum_job_driver;

  logic clk = 1'b0;
  logic rst_n;
  logic iv3, iv5, rr;
  logic [3:0] din;
  logic [7:0] tin;

  logic rdy3, en3, start3, busy3, done3, met3, rv3, rm3, rt3;
  logic [11:0] nf3;
  logic [6:0]  tg3;
  logic rdy5, en5, start5, busy5, done5, met5, rv5, rm5, rt5;
  logic [19:0] nf5;
  logic [7:0]  tg5;

  logic hang5;
  int   tc3, tc5;
  int   starts3, starts5;
  int   checks, failures;
  logic [3:0] beats [5];
  logic [1:0] q3 [$];
  logic [1:0] q5 [$];

  always #5 clk = ~clk;

  subset_sum_job_driver #(
    .N_of_numbers(3), .N_of_bits(4)
  ) u3 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv3), .in_ready(rdy3),
    .in_data(din), .in_target(tin[6:0]), .numbers_flat(nf3),
    .target(tg3), .en(en3), .start(start3), .busy(busy3),
    .done(done3), .isTargetMet(met3), .res_valid(rv3),
    .res_ready(rr), .res_met(rm3), .res_timeout(rt3)
  );

  subset_sum_job_driver #(
    .N_of_numbers(5), .N_of_bits(4)
`ifdef SUBSET_SUM_TIMEOUT_EN
    , .TIMEOUT_CYCLES(16)
`endif
  ) u5 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv5), .in_ready(rdy5),
    .in_data(din), .in_target(tin), .numbers_flat(nf5),
    .target(tg5), .en(en5), .start(start5), .busy(busy5),
    .done(done5), .isTargetMet(met5), .res_valid(rv5),
    .res_ready(rr), .res_met(rm5), .res_timeout(rt5)
  );

  function automatic bit subset_f(input logic [19:0] f, input int n,
                                  input int t);
    int s;
    for (int m = 0; m < (1 << n); m++) begin
      s = 0;
      for (int i = 0; i < n; i++)
        if (m[i]) s += int'(f[i*4 +: 4]);
      if (s == t) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Behavioural trees: drop done on start, raise it three cycles later.
  always @(posedge clk) begin
    if (!rst_n) begin
      done3 <= 1'b0; met3 <= 1'b0; tc3 <= 0;
    end else if (start3) begin
      done3 <= 1'b0; tc3 <= 3;
    end else if (tc3 != 0) begin
      tc3 <= tc3 - 1;
      if (tc3 == 1) begin
        done3 <= 1'b1;
        met3  <= subset_f({8'h00, nf3}, 3, int'(tg3));
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      done5 <= 1'b0; met5 <= 1'b0; tc5 <= 0;
    end else if (start5) begin
      done5 <= 1'b0; tc5 <= 3;
    end else if (tc5 != 0) begin
      tc5 <= tc5 - 1;
      if (tc5 == 1 && !hang5) begin
        done5 <= 1'b1;
        met5  <= subset_f(nf5, 5, int'(tg5));
      end
    end
  end

  assign busy3 = (tc3 != 0);
  assign busy5 = (tc5 != 0);

  always @(posedge clk) begin
    if (start3) starts3 <= starts3 + 1;
    if (start5) starts5 <= starts5 + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: compare each completed result handshake with the queue head.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && rv3 && rr) begin
      if (q3.size() == 0) chk("u3_unexpected_result", 1, 0);
      else begin
        e = q3.pop_front();
        chk("u3_res_met", 32'(rm3), 32'(e[0]));
        chk("u3_res_timeout", 32'(rt3), 32'(e[1]));
      end
    end
    if (rst_n && rv5 && rr) begin
      if (q5.size() == 0) chk("u5_unexpected_result", 1, 0);
      else begin
        e = q5.pop_front();
        chk("u5_res_met", 32'(rm5), 32'(e[0]));
        chk("u5_res_timeout", 32'(rt5), 32'(e[1]));
      end
    end
  end

  task automatic send_beat(input int s, input logic [3:0] d,
                           input logic [7:0] t);
    int k;
    bit ok;
    k = 0; ok = 1'b0;
    din = d; tin = t;
    if (s == 3) iv3 = 1'b1; else iv5 = 1'b1;
    while (!ok && k < 200) begin
      @(negedge clk);
      k++;
      ok = (s == 3) ? rdy3 : rdy5;
    end
    if (!ok) chk("beat_accept_timeout", 0, 1);
    @(posedge clk); #1;
    iv3 = 1'b0; iv5 = 1'b0;
  endtask

  task automatic send_job(input int s, input int n, input logic [7:0] t,
                          input bit gap);
    for (int i = 0; i < n; i++) begin
      send_beat(s, beats[i], t);
      if (gap && i != n - 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic wait_q(input int s);
    int k;
    k = 0;
    while (((s == 3) ? q3.size() : q5.size()) != 0 && k < 500) begin
      @(negedge clk);
      k++;
    end
    if (k >= 500) chk("result_wait_timeout", 0, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int k, s0;
    checks = 0; failures = 0; starts3 = 0; starts5 = 0;
    rst_n = 1'b0; iv3 = 1'b0; iv5 = 1'b0; rr = 1'b1;
    din = '0; tin = '0; hang5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'({rdy3, rdy5}), 0);
    chk("rst_en_start", 32'({en3, start3, en5, start5}), 0);
    chk("rst_res", 32'({rv3, rm3, rt3, rv5, rm5, rt5}), 0);
    chk("rst_flat", 32'({nf3, nf5}), 0);
    chk("rst_target", 32'({tg3, tg5}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // N=3: 2,5,9 target 14 -> 5+9
    beats[0] = 4'd2; beats[1] = 4'd5; beats[2] = 4'd9;
    q3.push_back(2'b01);
    send_job(3, 3, 8'd14, 1'b0);
    wait_q(3);
    chk("u3_flat", 32'(nf3), 32'h952);
    chk("u3_target", 32'(tg3), 32'd14);
    chk("u3_starts", 32'(starts3), 1);

    // N=5: 4,6,12,14,8 target 11 -> all even, unreachable
    beats[0] = 4'd4; beats[1] = 4'd6; beats[2] = 4'd12;
    beats[3] = 4'd14; beats[4] = 4'd8;
    q5.push_back(2'b00);
    send_job(5, 5, 8'd11, 1'b0);
    wait_q(5);
    chk("u5_flat_a", 32'(nf5), 32'h8EC64);
    chk("u5_target_a", 32'(tg5), 32'd11);

    // Same operands, target 22 -> 14+8, result held back by res_ready=0
    rr = 1'b0;
    q5.push_back(2'b01);
    send_job(5, 5, 8'd22, 1'b0);
    k = 0;
    while (!rv5 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!rv5) chk("hold_res_valid_timeout", 0, 1);
    @(posedge clk); #1;
    s0 = starts5;
    iv5 = 1'b1; din = 4'd7;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_res_valid", 32'(rv5), 1);
      chk("hold_res_met", 32'(rm5), 1);
      chk("hold_in_ready", 32'(rdy5), 0);
      chk("hold_no_start", 32'(starts5), 32'(s0));
    end
    @(posedge clk); #1;
    iv5 = 1'b0; rr = 1'b1;
    wait_q(5);
    chk("u5_flat_b", 32'(nf5), 32'h8EC64);
    chk("u5_target_b", 32'(tg5), 32'd22);

    // in_valid toggling: 1,2,3,4,5 target 15 -> all five
    beats[0] = 4'd1; beats[1] = 4'd2; beats[2] = 4'd3;
    beats[3] = 4'd4; beats[4] = 4'd5;
    s0 = starts5;
    q5.push_back(2'b01);
    send_job(5, 5, 8'd15, 1'b1);
    wait_q(5);
    chk("toggle_flat", 32'(nf5), 32'h54321);
    chk("toggle_starts", 32'(starts5 - s0), 1);

    // Reset while waiting on a tree that never finishes
    hang5 = 1'b1;
    beats[0] = 4'd3; beats[1] = 4'd3; beats[2] = 4'd3;
    beats[3] = 4'd3; beats[4] = 4'd3;
    send_job(5, 5, 8'd1, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("wait_en", 32'(en5), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("wrst_in_ready", 32'(rdy5), 0);
    chk("wrst_en_start", 32'({en5, start5}), 0);
    chk("wrst_res", 32'({rv5, rm5, rt5}), 0);
    chk("wrst_flat", 32'(nf5), 0);
    chk("wrst_target", 32'(tg5), 0);
    rst_n = 1'b1; hang5 = 1'b0;
    @(posedge clk); #1;
    chk("wrst_in_ready_after", 32'(rdy5), 1);
    beats[0] = 4'd4; beats[1] = 4'd6; beats[2] = 4'd12;
    beats[3] = 4'd14; beats[4] = 4'd8;
    q5.push_back(2'b01);
    send_job(5, 5, 8'd22, 1'b0);
    wait_q(5);
    chk("wrst_flat_after", 32'(nf5), 32'h8EC64);

`ifdef SUBSET_SUM_TIMEOUT_EN
    // Watchdog: START cycle, then 16 ARM/WAIT cycles, then res_valid
    hang5 = 1'b1;
    q5.push_back(2'b10);
    send_job(5, 5, 8'd22, 1'b0);
    k = 0;
    while (!rv5 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("timeout_latency", 32'(k), 32'd18);
    wait_q(5);
    hang5 = 1'b0;
`endif

    repeat (3) @(posedge clk);
    chk("q_drained", 32'(q3.size() + q5.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
